sqrt_arbiter: RTL and testbench
===============================

Name: sqrt_arbiter

Overview:
Shares one iterative square-root core among N_REQ requesters, for example CPU peripheral port and DMA/accelerator port. Arbitrates round-robin and launches the core with a one-cycle init pulse. Waits for the core's done pulse under a watchdog, then returns the result to the winning requester with an ID tag. Sits between the requester-side bus adapters and the sqrt datapath/controller pair.

Parameters:
N_REQ, 2, number of requesters (2..8)
WIDTH, 16, operand width in bits; must be even
TIMEOUT, 64, maximum WAIT cycles before the operation is aborted (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  N_REQ  level request per requester; operand must be stable while high
req_operand  in  N_REQ*WIDTH  packed operands; requester i uses bits [i*WIDTH +: WIDTH]
gnt  out  N_REQ  one-hot, one-cycle grant pulse
busy  out  1  high in any state other than IDLE
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  3  index of the served requester
rsp_result  out  WIDTH/2  square root result; 0 on timeout
rsp_timeout  out  1  qualifies rsp_valid; set when aborted by the watchdog
core_init  out  1  start pulse to the sqrt core
core_operand  out  WIDTH  latched operand to the core
core_rst  out  1  core reset = rst OR abort pulse
core_done  in  1  core completion pulse
core_result  in  WIDTH/2  core result, valid while core_done is high

Behaviour:
- Reset: state IDLE, rr pointer 0, operand/result/id/timer registers 0. All outputs 0, except core_rst = 1 while rst is high.
- FSM states: IDLE, LAUNCH, WAIT, RESP. Moore outputs; state and registers are updated on posedge clk.
- IDLE:
  - If any req is high, pick the first set req at or after ptr, wrapping modulo N_REQ.
  - Latch cur and req_operand[cur], then go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH (1 cycle):
  - gnt[cur]=1, core_init=1, timer cleared to 0.
  - core_done is ignored in this state.
  - Go to WAIT.
- WAIT:
  - If core_done=1: latch core_result and set timeout flag 0, go to RESP.
  - Else if timer==TIMEOUT-1: latch result 0 and set timeout flag 1, go to RESP.
  - Else timer+1.
  - If core_done and the timeout limit occur in the same cycle, done wins.
- RESP (1 cycle):
  - rsp_valid=1, rsp_id=cur, rsp_result, rsp_timeout driven from the latched values.
  - core_rst=1 only if the timeout flag is set.
  - ptr = (cur+1) mod N_REQ. Go to IDLE.
- Latency: req seen high in IDLE -> gnt one cycle later. rsp_valid comes one cycle after the core_done cycle. Minimum idle-to-idle time is 4 cycles plus core time.
- Requester protocol:
  - Drop req the cycle after seeing gnt; a req still high when the FSM returns to IDLE is treated as a new request.
  - Requests arriving while busy are not lost (level-held) and are arbitrated at the next IDLE.
  - req withdrawn before being granted: no effect.
- Fairness: with all requesters held high, grants rotate 0,1,..,N_REQ-1,0.
- core_operand holds its value from LAUNCH through RESP and does not change while busy.
- rst mid-operation: immediate return to IDLE and ptr=0; no rsp_valid is issued. core_rst is high during rst so the core returns to its start state.
- rsp_id is zero-extended when N_REQ<8.

Test Plan:
- Single request: req[0]=1, operand 144; core model gives done with result 12 after 20 cycles. Expect gnt[0] one cycle after req and core_init in the same cycle. Expect rsp_valid with id 0, result 12, timeout 0 one cycle after done.
- Simultaneous requests: req0 (operand 49) and req1 (operand 225) both set after reset. Expect served order 0 then 1, with results 7 then 15.
- Fairness: req0 and req1 held high continuously for 6 operations. Expect gnt order 0,1,0,1,0,1 and busy high except in IDLE cycles.
- Timeout: core never asserts done, TIMEOUT=8. Expect rsp_valid exactly 8 cycles after the LAUNCH cycle ends, with timeout 1, result 0, and a core_rst pulse in the same cycle.
- Edge cases: done pulsed during LAUNCH is ignored and the FSM keeps waiting. done on the final WAIT cycle gives timeout 0 with the real result.
- Reset in WAIT: assert rst. Expect no rsp_valid, gnt 0, busy 0 next cycle, ptr 0. The next request from requester 1 with operand 16 is served with result 4.

Source files
------------

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : sqrt_arbiter
// Description : Round-robin arbiter sharing one iterative square-root core
//               among N_REQ requesters, with a watchdog on the core's done.
// Revision    : 1.0  initial release
// =============================================================================
module sqrt_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_operand,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_id,
    output logic [WIDTH/2-1:0]       rsp_result,
    output logic                     rsp_timeout,
    output logic                     core_init,
    output logic [WIDTH-1:0]         core_operand,
    output logic                     core_rst,
    input  logic                     core_done,
    input  logic [WIDTH/2-1:0]       core_result
);

    localparam int C_PTR_W = $clog2(N_REQ);
    localparam int C_TMR_W = $clog2(TIMEOUT);
    localparam int C_RES_W = WIDTH / 2;

    localparam logic [C_PTR_W:0]   C_NREQ    = (C_PTR_W + 1)'(N_REQ);
    localparam logic [C_PTR_W-1:0] C_LAST    = C_PTR_W'(N_REQ - 1);
    localparam logic [C_TMR_W-1:0] C_TMR_MAX = C_TMR_W'(TIMEOUT - 1);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("sqrt_arbiter: N_REQ must be in 2..8");
    end
    if (WIDTH % 2 != 0) begin : g_bad_width
        $error("sqrt_arbiter: WIDTH must be even");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("sqrt_arbiter: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [C_PTR_W-1:0]   ptr_q,     ptr_d;
    logic [C_PTR_W-1:0]   cur_q,     cur_d;
    logic [WIDTH-1:0]     operand_q, operand_d;
    logic [C_RES_W-1:0]   result_q,  result_d;
    logic                 timeout_q, timeout_d;
    logic [C_TMR_W-1:0]   timer_q,   timer_d;

    logic [WIDTH-1:0]     w_ops [N_REQ];
    logic                 w_found;
    logic [C_PTR_W-1:0]   w_pick;
    logic [C_PTR_W:0]     w_slot;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_ops[gi] = req_operand[gi*WIDTH +: WIDTH];
    end

    // Scan requesters starting at ptr, wrapping once; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_slot  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_slot = {1'b0, ptr_q} + (C_PTR_W + 1)'(k);
            if (w_slot >= C_NREQ) begin
                w_slot = w_slot - C_NREQ;
            end
            if (!w_found && req[w_slot[C_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_slot[C_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        operand_d = operand_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        timer_d   = timer_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    cur_d     = w_pick;
                    operand_d = w_ops[w_pick];
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the last permitted cycle still counts.
                if (core_done) begin
                    result_d  = core_result;
                    timeout_d = 1'b0;
                    state_d   = S_RESP;
                end else if (timer_q == C_TMR_MAX) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    timer_d = timer_q + C_TMR_W'(1);
                end
            end
            S_RESP: begin
                ptr_d   = (cur_q == C_LAST) ? '0 : cur_q + C_PTR_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cur_q     <= '0;
            operand_q <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == S_LAUNCH) begin
            gnt[cur_q] = 1'b1;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign core_init    = (state_q == S_LAUNCH);
    assign core_operand = operand_q;
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_id       = (state_q == S_RESP) ? 3'(cur_q) : 3'd0;
    assign rsp_result   = (state_q == S_RESP) ? result_q : '0;
    assign rsp_timeout  = (state_q == S_RESP) && timeout_q;
    // An aborted core is parked back in its start state alongside the response.
    assign core_rst     = rst || ((state_q == S_RESP) && timeout_q);

endmodule
`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_sqrt_arbiter
// Description : Self-checking bench for sqrt_arbiter with a behavioural core.
// Revision    : 1.0  initial release
// =============================================================================
module tb_sqrt_arbiter;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int RW = W / 2;
    localparam int TO = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_operand = '0;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             rsp_valid;
    logic [2:0]       rsp_id;
    logic [RW-1:0]    rsp_result;
    logic             rsp_timeout;
    logic             core_init;
    logic [W-1:0]     core_operand;
    logic             core_rst;
    logic             core_done = 1'b0;
    logic [RW-1:0]    core_result = '0;

    int n_tests = 0;
    int n_fail  = 0;

    int            core_lat = 1;
    bit            launch_glitch = 1'b0;
    int            core_cnt = 0;
    bit            core_active = 1'b0;
    logic [RW-1:0] core_hold = '0;

    sqrt_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_operand (req_operand),
        .gnt         (gnt),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .core_init   (core_init),
        .core_operand(core_operand),
        .core_rst    (core_rst),
        .core_done   (core_done),
        .core_result (core_result)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] isqrt(input logic [W-1:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return RW'(r);
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Core model: done is raised in the core_lat-th cycle after the init cycle.
    always @(negedge clk) begin
        if (core_rst) begin
            core_active = 1'b0;
            core_done   = 1'b0;
        end else if (core_init) begin
            core_active = 1'b1;
            core_cnt    = core_lat;
            core_hold   = isqrt(core_operand);
            core_result = launch_glitch ? 8'hA5 : core_hold;
            core_done   = launch_glitch;
        end else if (core_active) begin
            core_cnt--;
            core_result = core_hold;
            core_done   = (core_cnt == 0);
            if (core_cnt == 0) core_active = 1'b0;
        end else begin
            core_done = 1'b0;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n++;
            if (gnt != '0) return;
        end
        n = -1;
    endtask

    task automatic run_op(input int lat, input bit drop, output int ngnt,
                          output logic [N-1:0] g, output logic [W-1:0] op,
                          output int nrsp, output logic [2:0] id,
                          output logic [RW-1:0] res, output logic to,
                          output logic crst, output bit busy_ok, output bit quiet_ok);
        core_lat = lat;
        busy_ok = 1'b1; quiet_ok = 1'b1; id = '0; res = '0; to = 1'b0; crst = 1'b0;
        nrsp = -1;
        wait_gnt(ngnt);
        g  = gnt;
        op = core_operand;
        if (ngnt < 0) return;
        if (drop) req = req & ~gnt;
        nrsp = 0;
        for (int i = 0; i < TO + 50; i++) begin
            cyc();
            nrsp++;
            if (rsp_valid) begin
                id = rsp_id; res = rsp_result; to = rsp_timeout; crst = core_rst;
                return;
            end
            if (!busy) busy_ok = 1'b0;
            if (gnt != '0 || core_init || core_operand != op) quiet_ok = 1'b0;
        end
        nrsp = -1;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        n_tests++; if (gnt !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: gnt=%0d busy=%0d rsp_valid=%0d want 0/0/0", gnt, busy, rsp_valid); end
        n_tests++; if (rsp_id !== 3'd0 || rsp_result !== '0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: id=%0d res=%0d to=%0d want 0", rsp_id, rsp_result, rsp_timeout); end
        n_tests++; if (core_init !== 1'b0 || core_operand !== '0) begin n_fail++; $display("FAIL reset_core: init=%0d op=%0d want 0", core_init, core_operand); end
        n_tests++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %0d want 1", core_rst); end
        rst = 1'b0;
        cyc();
        n_tests++; if (core_rst !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: core_rst=%0d busy=%0d want 0/0", core_rst, busy); end
    endtask

    task automatic test_single();
        int ng, nr; logic [N-1:0] g; logic [W-1:0] op; logic [2:0] id;
        logic [RW-1:0] res; logic to, cr; bit bok, qok;
        do_reset();
        req_operand[0 +: W] = 16'd144;
        req = 2'b01;
        run_op(20, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        n_tests++; if (ng !== 1) begin n_fail++; $display("FAIL single_gnt_latency: got %0d want 1", ng); end
        n_tests++; if (g !== 2'b01 || op !== 16'd144) begin n_fail++; $display("FAIL single_launch: gnt=%0d op=%0d want 1/144", g, op); end
        n_tests++; if (nr !== 21) begin n_fail++; $display("FAIL single_rsp_latency: got %0d want 21", nr); end
        n_tests++; if (id !== 3'd0 || res !== 8'd12 || to !== 1'b0 || cr !== 1'b0) begin n_fail++; $display("FAIL single_rsp: id=%0d res=%0d to=%0d crst=%0d want 0/12/0/0", id, res, to, cr); end
        n_tests++; if (!bok || !qok) begin n_fail++; $display("FAIL single_wait_quiet: busy_ok=%0d quiet_ok=%0d want 1/1", bok, qok); end
        cyc();
        n_tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%0d rsp_valid=%0d want 0/0", busy, rsp_valid); end
    endtask

    task automatic test_simultaneous();
        int ng, nr; logic [N-1:0] g; logic [W-1:0] op; logic [2:0] id;
        logic [RW-1:0] res; logic to, cr; bit bok, qok;
        do_reset();
        req_operand = {16'd225, 16'd49};
        req = 2'b11;
        run_op(6, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        n_tests++; if (g !== 2'b01 || id !== 3'd0 || res !== 8'd7 || nr !== 7) begin n_fail++; $display("FAIL simul_first: gnt=%0d id=%0d res=%0d lat=%0d want 1/0/7/7", g, id, res, nr); end
        run_op(9, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        n_tests++; if (g !== 2'b10 || id !== 3'd1 || res !== 8'd15 || op !== 16'd225) begin n_fail++; $display("FAIL simul_second: gnt=%0d id=%0d res=%0d op=%0d want 2/1/15/225", g, id, res, op); end
    endtask

    task automatic test_fairness();
        int ng, nr; logic [N-1:0] g; logic [W-1:0] op; logic [2:0] id;
        logic [RW-1:0] res; logic to, cr; bit bok, qok;
        logic [W-1:0] opv [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            opv[i] = W'($urandom);
            req_operand[i*W +: W] = opv[i];
        end
        req = '1;
        for (int k = 0; k < 6; k++) begin
            run_op($urandom_range(1, TO), 1'b0, ng, g, op, nr, id, res, to, cr, bok, qok);
            n_tests++; if (g !== N'(1 << (k % N)) || id !== 3'(k % N)) begin n_fail++; $display("FAIL fair_order[%0d]: gnt=%0d id=%0d want id %0d", k, g, id, k % N); end
            n_tests++; if (res !== isqrt(opv[k % N]) || to !== 1'b0 || !bok) begin n_fail++; $display("FAIL fair_result[%0d]: res=%0d to=%0d busy_ok=%0d want %0d/0/1", k, res, to, bok, isqrt(opv[k % N])); end
            n_tests++; if (k > 0 && ng !== 1) begin n_fail++; $display("FAIL fair_gap[%0d]: gnt after %0d want 1", k, ng); end
            cyc();
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_idle[%0d]: busy=%0d want 0", k, busy); end
        end
        req = '0;
    endtask

    task automatic test_timeout();
        int ng, nr; logic [N-1:0] g; logic [W-1:0] op; logic [2:0] id;
        logic [RW-1:0] res; logic to, cr; bit bok, qok;
        req_operand[W +: W] = W'($urandom);
        req = 2'b10;
        run_op(1000, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        n_tests++; if (nr !== TO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", nr, TO + 1); end
        n_tests++; if (id !== 3'd1 || res !== '0 || to !== 1'b1 || cr !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp: id=%0d res=%0d to=%0d crst=%0d want 1/0/1/1", id, res, to, cr); end
        cyc();
        n_tests++; if (core_rst !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_after: core_rst=%0d busy=%0d want 0/0", core_rst, busy); end
    endtask

    task automatic test_edges();
        int ng, nr; logic [N-1:0] g; logic [W-1:0] op; logic [2:0] id;
        logic [RW-1:0] res; logic to, cr; bit bok, qok;
        launch_glitch = 1'b1;
        req_operand[0 +: W] = 16'd400;
        req = 2'b01;
        run_op(5, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        launch_glitch = 1'b0;
        n_tests++; if (nr !== 6 || res !== 8'd20 || to !== 1'b0) begin n_fail++; $display("FAIL launch_done_ignored: lat=%0d res=%0d to=%0d want 6/20/0", nr, res, to); end
        req_operand[0 +: W] = 16'd10000;
        req = 2'b01;
        run_op(TO, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        n_tests++; if (nr !== TO + 1 || res !== 8'd100 || to !== 1'b0 || cr !== 1'b0) begin n_fail++; $display("FAIL done_last_cycle: lat=%0d res=%0d to=%0d crst=%0d want %0d/100/0/0", nr, res, to, cr, TO + 1); end
        req_operand[0 +: W] = 16'd10000;
        req = 2'b01;
        run_op(TO + 1, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        n_tests++; if (nr !== TO + 1 || res !== '0 || to !== 1'b1) begin n_fail++; $display("FAIL done_too_late: lat=%0d res=%0d to=%0d want %0d/0/1", nr, res, to, TO + 1); end
    endtask

    task automatic test_reset_in_wait();
        int ng, nr; logic [N-1:0] g; logic [W-1:0] op; logic [2:0] id;
        logic [RW-1:0] res; logic to, cr; bit bok, qok; bit stray;
        do_reset();
        req_operand = {16'd100, 16'd144};
        req = 2'b01;
        run_op(3, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        n_tests++; if (id !== 3'd0 || res !== 8'd12) begin n_fail++; $display("FAIL rstwait_pre: id=%0d res=%0d want 0/12", id, res); end
        req = 2'b10;
        core_lat = 20;
        wait_gnt(ng);
        n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rstwait_gnt: got %0d want 2", gnt); end
        req = '0;
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        n_tests++; if (rsp_valid !== 1'b0 || gnt !== '0 || busy !== 1'b0 || core_rst !== 1'b1) begin n_fail++; $display("FAIL rstwait_abort: rsp_valid=%0d gnt=%0d busy=%0d core_rst=%0d want 0/0/0/1", rsp_valid, gnt, busy, core_rst); end
        rst = 1'b0;
        stray = 1'b0;
        repeat (30) begin cyc(); if (rsp_valid) stray = 1'b1; end
        n_tests++; if (stray !== 1'b0) begin n_fail++; $display("FAIL rstwait_no_rsp: stray rsp_valid seen=%0d want 0", stray); end
        req_operand = {16'd16, 16'd49};
        req = 2'b11;
        run_op(4, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        n_tests++; if (g !== 2'b01 || res !== 8'd7) begin n_fail++; $display("FAIL rstwait_ptr0: gnt=%0d res=%0d want 1/7", g, res); end
        run_op(4, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
        n_tests++; if (g !== 2'b10 || id !== 3'd1 || res !== 8'd4 || to !== 1'b0) begin n_fail++; $display("FAIL rstwait_req1: gnt=%0d id=%0d res=%0d to=%0d want 2/1/4/0", g, id, res, to); end
    endtask

    task automatic test_random();
        int ng, nr; logic [N-1:0] g; logic [W-1:0] op; logic [2:0] id;
        logic [RW-1:0] res; logic to, cr; bit bok, qok;
        logic [W-1:0] opv [N];
        logic [N-1:0] reqv, eg;
        int ptr, lat, eid, j;
        bit eto;
        do_reset();
        ptr = 0; reqv = '0;
        for (int i = 0; i < N; i++) opv[i] = '0;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!reqv[i] && $urandom_range(0, 1) == 1) begin reqv[i] = 1'b1; opv[i] = W'($urandom); end
            end
            if (reqv == '0) begin j = $urandom_range(0, N - 1); reqv[j] = 1'b1; opv[j] = W'($urandom); end
            for (int i = 0; i < N; i++) req_operand[i*W +: W] = opv[i];
            req = reqv;
            lat = $urandom_range(1, TO + 3);
            eid = rr_pick(ptr, reqv);
            eto = (lat > TO);
            eg = '0; eg[eid] = 1'b1;
            run_op(lat, 1'b1, ng, g, op, nr, id, res, to, cr, bok, qok);
            n_tests++; if (g !== eg || id !== 3'(eid) || op !== opv[eid]) begin n_fail++; $display("FAIL rand_pick[%0d]: gnt=%0d id=%0d op=%0d want %0d/%0d/%0d", it, g, id, op, eg, eid, opv[eid]); end
            n_tests++; if (res !== (eto ? RW'(0) : isqrt(opv[eid])) || to !== eto || cr !== eto) begin n_fail++; $display("FAIL rand_rsp[%0d]: res=%0d to=%0d crst=%0d lat=%0d", it, res, to, cr, lat); end
            n_tests++; if (nr !== (eto ? TO : lat) + 1 || !qok) begin n_fail++; $display("FAIL rand_timing[%0d]: rsp after %0d quiet=%0d want %0d/1", it, nr, qok, (eto ? TO : lat) + 1); end
            reqv[eid] = 1'b0;
            ptr = (eid + 1) % N;
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_edges();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_tests);
        $fatal(1);
    end

endmodule
`default_nettype wire
